// File: rtl/red_pitaya_lpf_inverse_block_pkg.sv
// Shared definitions for the lowpass-inverse filter and its saturator.
// Holds the clog2 helper, the derived shift limit, the FSM encoding,
// the priming length and a signed saturate helper with clip flag.
package red_pitaya_lpf_inverse_block_pkg;

   // Smallest r with 2^r >= v.
   function automatic int unsigned clog2_f(input longint unsigned v);
      int unsigned     r;
      longint unsigned t;
      r = 0;
      t = 64'd1;
      while (t < v) begin
         t = t << 1;
         r = r + 1;
      end
      return r;
   endfunction

   localparam int unsigned CLK_HZ       = 125000000;
   localparam int unsigned MINBW_DEF    = 10;
   localparam int unsigned MAXSHIFT_DEF = clog2_f(CLK_HZ / MINBW_DEF);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } lpf_inv_state_t;

   // Cycles spent in PRIME before the inverse path is trusted.
   localparam int unsigned PRIME_CYCLES = 2;
   localparam int unsigned PRIME_CNT_W  = 2;

   // value holds the clipped result as a 64-bit two's complement word.
   typedef struct packed {
      logic [63:0] value;
      logic        clip;
   } sat_result_t;

   // Clip a signed value to the range of an out_w-bit signed word.
   function automatic sat_result_t sat_signed(input logic signed [63:0] v,
                                              input int unsigned       out_w);
      sat_result_t        r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      r.clip = 1'b1;
      if (v > hi) begin
         r.value = hi;
      end else if (v < lo) begin
         r.value = lo;
      end else begin
         r.value = v;
         r.clip  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/red_pitaya_sat_block.sv
// Registered signed saturator with a clip flag, shared by filter stages.
// data_o/clip_o update one cycle after data_i; reset clears both.
module red_pitaya_sat_block
   import red_pitaya_lpf_inverse_block_pkg::*;
#(
   parameter int unsigned IN_W  = 40,
   parameter int unsigned OUT_W = 14
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic signed [IN_W-1:0]  data_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    clip_o
);

   logic signed [63:0] data_ext;
   sat_result_t        sat_r;
   logic               sat_unused;

   // Widen to the helper's word size and clip combinationally.
   always_comb begin
      data_ext = 64'(data_i);
      sat_r    = sat_signed(data_ext, OUT_W);
   end

   // Upper bits of the clipped word are pure sign extension.
   assign sat_unused = ^sat_r.value[63:OUT_W];

   // Register the clipped value and its flag.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         data_o <= '0;
         clip_o <= 1'b0;
      end else begin
         data_o <= sat_r.value[OUT_W-1:0];
         clip_o <= sat_r.clip;
      end
   end

endmodule

// File: rtl/red_pitaya_lpf_inverse_block.sv
// Pole-cancelling inverse of the shift-based first-order lowpass:
//   x_hat[n] = y[n-1] + 2^s * (y[n] - y[n-1])
// Three-stage pipeline with fixed 3-cycle latency in every mode, a priming
// FSM (OFF/PRIME/RUN) that holds bypass output until the delay line is
// filled with samples taken under the current shift, and a saturated output.
// Optional macro LPF_INVERSE_SATCNT_EN adds sat_cnt_o, a 16-bit saturating
// count of clipped RUN cycles, cleared while OFF.
// state_o exposes the FSM state for observation.
// The block has no handshake: one sample is consumed and produced per clock.
module red_pitaya_lpf_inverse_block
   import red_pitaya_lpf_inverse_block_pkg::*;
#(
   parameter int unsigned SHIFTBITS  = 4,
   parameter int unsigned SIGNALBITS = 14,
   parameter int unsigned MINBW      = 10
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [SHIFTBITS:0]           shift,
   input  logic                         filter_on,
   input  logic signed [SIGNALBITS-1:0] signal_i,
   output logic signed [SIGNALBITS-1:0] signal_o,
   output logic                         sat_o,
   output logic [1:0]                   state_o
`ifdef LPF_INVERSE_SATCNT_EN
   ,
   output logic [15:0]                  sat_cnt_o
`endif
);

   localparam int unsigned MAXSHIFT = clog2_f(CLK_HZ / MINBW);
   localparam int unsigned SHIFT_W  = SHIFTBITS + 1;
   localparam int unsigned ACC_W    = SIGNALBITS + MAXSHIFT + 2;
   localparam logic [SHIFT_W-1:0]     MAXSHIFT_S = SHIFT_W'(MAXSHIFT);
   localparam logic [PRIME_CNT_W-1:0] PRIME_LOAD = PRIME_CNT_W'(PRIME_CYCLES);
   localparam logic [PRIME_CNT_W-1:0] PRIME_ONE  = PRIME_CNT_W'(1);

   // Shift handling
   logic [SHIFT_W-1:0] shift_eff;
   logic [SHIFT_W-1:0] shift_q;
   logic               shift_chg;

   // Pipeline
   logic signed [SIGNALBITS-1:0] d1;
   logic signed [SIGNALBITS-1:0] d2;
   logic signed [SIGNALBITS-1:0] byp;
   logic signed [SIGNALBITS:0]   diff;
   logic signed [ACC_W-1:0]      diff_ext;
   logic signed [ACC_W-1:0]      d2_ext;
   logic signed [ACC_W-1:0]      acc_next;
   logic signed [ACC_W-1:0]      acc;
   logic signed [ACC_W-1:0]      sel;

   // FSM
   lpf_inv_state_t          state_q;
   lpf_inv_state_t          state_d;
   logic [PRIME_CNT_W-1:0]  cnt_q;
   logic [PRIME_CNT_W-1:0]  cnt_d;

   // Clamp the requested shift; larger values would exceed the accumulator.
   always_comb begin
      shift_eff = (shift > MAXSHIFT_S) ? MAXSHIFT_S : shift;
      shift_chg = (shift_eff != shift_q);
   end

   // Shadow copy of the effective shift, used to detect changes.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_eff;
      end
   end

   // Difference is one bit wider than the signal; the shifted difference
   // plus d2 always fits in ACC_W bits even at MAXSHIFT.
   always_comb begin
      diff     = (SIGNALBITS + 1)'(d1) - (SIGNALBITS + 1)'(d2);
      diff_ext = ACC_W'(diff);
      d2_ext   = ACC_W'(d2);
      acc_next = d2_ext + (diff_ext <<< shift_eff);
   end

   // S1 delay line and S2 gain/bypass stage, running in every state.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         d1  <= '0;
         d2  <= '0;
         acc <= '0;
         byp <= '0;
      end else begin
         d1  <= signal_i;
         d2  <= d1;
         acc <= acc_next;
         byp <= d1;
      end
   end

   // S3 source: the inverse result only in RUN. byp never clips, so sat_o
   // can only rise while running.
   always_comb begin
      sel = (state_q == ST_RUN) ? acc : ACC_W'(byp);
   end

   red_pitaya_sat_block #(
      .IN_W  (ACC_W),
      .OUT_W (SIGNALBITS)
   ) u_sat (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .data_i (sel),
      .data_o (signal_o),
      .clip_o (sat_o)
   );

   // FSM state and prime counter registers.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: disabling always wins; a shift change restarts priming.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_OFF: begin
            if (filter_on) begin
               state_d = ST_PRIME;
               cnt_d   = PRIME_LOAD;
            end
         end
         ST_PRIME: begin
            if (!filter_on) begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end else if (shift_chg) begin
               cnt_d   = PRIME_LOAD;
            end else if (cnt_q == PRIME_ONE) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - PRIME_ONE;
            end
         end
         ST_RUN: begin
            if (!filter_on) begin
               state_d = ST_OFF;
            end else if (shift_chg) begin
               state_d = ST_PRIME;
               cnt_d   = PRIME_LOAD;
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   assign state_o = state_q;

`ifdef LPF_INVERSE_SATCNT_EN
   // Count clipped output cycles; sticks at all-ones, cleared while OFF.
   always_ff @(posedge clk_i) begin
      if (!rstn_i || (state_q == ST_OFF)) begin
         sat_cnt_o <= '0;
      end else if (sat_o && (sat_cnt_o != 16'hFFFF)) begin
         sat_cnt_o <= sat_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_red_pitaya_lpf_inverse_block.sv
// Bench for red_pitaya_lpf_inverse_block. The reference model works from the
// recorded history of sampled inputs: the output three edges later is either
// the raw delayed sample or y[n-1] + 2^s*(y[n]-y[n-1]) clipped, and the
// filter counts as running once filter_on has been high for three sampled
// edges with the effective shift unchanged over the last two.
module tb_red_pitaya_lpf_inverse_block;

   localparam int SIGNALBITS = 14;
   localparam int SHIFTBITS  = 4;
   localparam int MAXSHIFT   = 24;
   localparam int HIST       = 4096;
   localparam longint SAT_HI = 8191;
   localparam longint SAT_LO = -8192;

   logic                         clk_i;
   logic                         rstn_i;
   logic [SHIFTBITS:0]           shift;
   logic                         filter_on;
   logic signed [SIGNALBITS-1:0] signal_i;
   logic signed [SIGNALBITS-1:0] signal_o;
   logic                         sat_o;
   logic [1:0]                   state_o;
`ifdef LPF_INVERSE_SATCNT_EN
   logic [15:0]                  sat_cnt_o;
   longint                       cnt_model;
   bit                           prev_sat;
`endif

   red_pitaya_lpf_inverse_block dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .shift     (shift),
      .filter_on (filter_on),
      .signal_i  (signal_i),
      .signal_o  (signal_o),
      .sat_o     (sat_o),
      .state_o   (state_o)
`ifdef LPF_INVERSE_SATCNT_EN
      ,
      .sat_cnt_o (sat_cnt_o)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #4 clk_i = ~clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish (got running, need finished)");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int     n_chk;
   int     n_err;
   int     k;
   string  phase;
   bit     rt_mode;
   logic [SIGNALBITS:0] exp_q[$];

   longint x_h   [HIST];
   longint xsrc_h[HIST];
   int     sh_h  [HIST];
   bit     fon_h [HIST];
   bit     rst_h [HIST];

   task automatic check_value(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, k, got, exp);
      end
   endtask

   function automatic bit run_at(int j);
      if (j < 2) return 1'b0;
      return fon_h[j] && fon_h[j-1] && fon_h[j-2] &&
             (sh_h[j] == sh_h[j-1]) && (sh_h[j-1] == sh_h[j-2]);
   endfunction

   function automatic longint clamp(longint v);
      if (v > SAT_HI) return SAT_HI;
      if (v < SAT_LO) return SAT_LO;
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_cycle(input int x, input bit fon, input int sh, input bit rst);
      longint out_e;
      longint a;
      bit     sat_e;
      int     st_e;
      int     idx;
      logic [SIGNALBITS:0] e;
      signal_i  = SIGNALBITS'(x);
      filter_on = fon;
      shift     = (SHIFTBITS + 1)'(sh);
      rstn_i    = !rst;
      @(posedge clk_i);
      idx = k;
      // Record what the design sampled; reset clears the delay line.
      rst_h[idx] = rst;
      x_h[idx]   = rst ? 0 : x;
      if (rst && idx > 0) x_h[idx-1] = 0;
      fon_h[idx] = rst ? 1'b0 : fon;
      sh_h[idx]  = rst ? 0 : ((sh > MAXSHIFT) ? MAXSHIFT : sh);

      sat_e = 1'b0;
      if (rst || idx < 3) begin
         out_e = 0;
      end else if (run_at(idx-1)) begin
         a     = x_h[idx-3] + (x_h[idx-2] - x_h[idx-3]) * (longint'(1) << sh_h[idx-1]);
         out_e = clamp(a);
         sat_e = (out_e != a);
      end else begin
         out_e = x_h[idx-2];
      end
      if (!fon_h[idx])      st_e = 0;
      else if (run_at(idx)) st_e = 2;
      else                  st_e = 1;
      exp_q.push_back({sat_e, SIGNALBITS'(out_e)});

      #1;
      e = exp_q.pop_front();
      check_value({phase, "/signal_o"}, longint'(signal_o), longint'($signed(e[SIGNALBITS-1:0])));
      check_value({phase, "/sat_o"}, longint'(sat_o), longint'(e[SIGNALBITS]));
      check_value({phase, "/state"}, longint'(state_o), longint'(st_e));
      // Floor-quantised lowpass loses up to 2^4-1 LSB per sample.
      if (rt_mode && !rst && run_at(idx-1)) begin
         a = longint'(signal_o) - xsrc_h[idx-2];
         check_value({phase, "/err_in_[-15,0]"}, longint'(a >= -15 && a <= 0), 1);
      end
`ifdef LPF_INVERSE_SATCNT_EN
      if (rst || (idx > 0 && !fon_h[idx-1])) cnt_model = 0;
      else if (prev_sat && cnt_model < 65535) cnt_model++;
      prev_sat = sat_e;
      check_value({phase, "/sat_cnt_o"}, longint'(sat_cnt_o), cnt_model);
`endif
      k++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int sh;
      int x;
      int y_prev;
      int x_prev;
      int y;
      bit fon;
      n_chk = 0;
      n_err = 0;
      k     = 0;
      rt_mode = 1'b0;
`ifdef LPF_INVERSE_SATCNT_EN
      cnt_model = 0;
      prev_sat  = 1'b0;
`endif

      phase = "reset";
      repeat (3) drive_cycle(1234, 1'b1, 5, 1'b1);

      phase = "bypass";
      for (int i = -5; i <= 5; i++) drive_cycle(i, 1'b0, 2, 1'b0);
      repeat (3) drive_cycle(0, 1'b0, 2, 1'b0);

      phase = "step_s2";
      repeat (6) drive_cycle(0, 1'b1, 2, 1'b0);
      repeat (5) drive_cycle(100, 1'b1, 2, 1'b0);

      phase = "step_s0";
      repeat (6) drive_cycle(0, 1'b1, 0, 1'b0);
      repeat (5) drive_cycle(100, 1'b1, 0, 1'b0);

      phase = "sat_pos_neg";
      repeat (6) drive_cycle(0, 1'b1, 4, 1'b0);
      repeat (4) drive_cycle(1000, 1'b1, 4, 1'b0);
      repeat (4) drive_cycle(0, 1'b1, 4, 1'b0);
      repeat (4) drive_cycle(-1000, 1'b1, 4, 1'b0);

      phase = "priming";
      repeat (4) drive_cycle(50, 1'b0, 4, 1'b0);
      repeat (8) drive_cycle(50, 1'b1, 4, 1'b0);
      repeat (6) drive_cycle(50, 1'b1, 3, 1'b0);

      phase = "shift_cap";
      repeat (5) drive_cycle(10, 1'b1, 24, 1'b0);
      drive_cycle(11, 1'b1, 31, 1'b0);
      repeat (3) drive_cycle(10, 1'b1, 30, 1'b0);
      repeat (3) drive_cycle(-9, 1'b1, 25, 1'b0);
      repeat (3) drive_cycle(-9, 1'b1, 24, 1'b0);

      phase = "random";
      sh = 3;
      for (int i = 0; i < 400; i++) begin
         x   = int'($urandom_range(0, 16383)) - 8192;
         if ($urandom_range(0, 3) == 0) x = x / 64;
         fon = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 19) == 0) sh = int'($urandom_range(0, 31));
         drive_cycle(x, fon, sh, 1'b0);
      end

      phase = "round_trip";
      rt_mode = 1'b1;
      y_prev = 0;
      x_prev = 0;
      for (int i = 0; i < 400; i++) begin
         y = y_prev + ((x_prev - y_prev) >>> 4);
         xsrc_h[k] = x_prev;
         drive_cycle(y, 1'b1, 4, 1'b0);
         y_prev = y;
         x_prev = int'($urandom_range(0, 4095)) - 2048;
      end
      rt_mode = 1'b0;

      phase = "reset_mid";
      repeat (6) drive_cycle(3000, 1'b1, 2, 1'b0);
      drive_cycle(3000, 1'b1, 2, 1'b1);
      repeat (6) drive_cycle(3000, 1'b1, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
